// File: rtl/vf_ramp_ctrl.sv
// vf_ramp_ctrl: V/f frequency ramp scheduler with amplitude law and driver gating; VF_BOOST_EN adds a low-speed amplitude floor
module vf_ramp_ctrl #(
  parameter int FREQ_W    = 10,
  parameter int F_MIN     = 10,
  parameter int F_MAX     = 600,
  parameter int RAMP_DIV  = 50000,
  parameter int VF_GAIN   = 109,
  parameter int BOOST_AMP = 410
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              fault_in,
  input  logic              fault_clr,
  input  logic [FREQ_W-1:0] f_target,
  output logic [FREQ_W-1:0] freq_out,
  output logic [11:0]       amp_out,
  output logic              update,
  output logic              gate_en,
  output logic [2:0]        state_out,
  output logic              fault_latched
);
  localparam logic [2:0] IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, STOPPING = 3'd3, FAULT = 3'd4;
  localparam int CNT_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int PW = FREQ_W + 7;
  localparam logic [FREQ_W-1:0] FMIN = FREQ_W'(F_MIN);
  localparam logic [FREQ_W-1:0] FMAX = FREQ_W'(F_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(RAMP_DIV - 1);
  localparam logic [PW-1:0] GAIN = PW'(VF_GAIN);
  localparam logic [PW-1:0] AMP_SAT = PW'(4095);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tick;
  logic [2:0] state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d, tgt, step, ramp_f;
  logic gate_q, gate_d, upd_q, flt_q;
  logic [11:0] amp_q, amp_d, vf_amp;
  logic [PW-1:0] prod;
  assign tick = cnt_q == CNT_TOP;
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign tgt = f_target < FMIN ? FMIN : f_target > FMAX ? FMAX : f_target;
  assign step = freq_q < tgt ? freq_q + 1'b1 : freq_q > tgt ? freq_q - 1'b1 : freq_q;
  assign ramp_f = tick ? step : freq_q;
  assign prod = PW'(freq_q) * GAIN;
  assign vf_amp = (prod >> 4) > AMP_SAT ? 12'hfff : 12'(prod >> 4);
  // Amplitude follows the previous frequency and is forced to zero with the driver off
`ifdef VF_BOOST_EN
  localparam logic [11:0] BOOST = 12'(BOOST_AMP);
  assign amp_d = !gate_d ? '0 : vf_amp < BOOST ? BOOST : vf_amp;
`else
  assign amp_d = gate_d ? vf_amp : '0;
`endif
  // Next state: fault overrides everything, stop overrides start and target changes
  always_comb begin
    state_d = state_q;
    freq_d = freq_q;
    gate_d = gate_q;
    if (fault_in) begin
      state_d = FAULT;
      freq_d = '0;
      gate_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          freq_d = start && !stop && f_target != '0 ? FMIN : '0;
          gate_d = start && !stop && f_target != '0;
          state_d = start && !stop && f_target != '0 ? RAMP : IDLE;
        end
        RAMP: begin
          freq_d = stop || !start ? freq_q : ramp_f;
          state_d = stop || !start ? STOPPING : ramp_f == tgt ? RUN : RAMP;
        end
        RUN: state_d = stop || !start ? STOPPING : tgt != freq_q ? RAMP : RUN;
        STOPPING: begin
          state_d = freq_q <= FMIN ? IDLE : STOPPING;
          freq_d = freq_q <= FMIN ? '0 : tick ? freq_q - 1'b1 : freq_q;
          gate_d = freq_q > FMIN;
        end
        FAULT: begin
          state_d = fault_clr ? IDLE : FAULT;
          freq_d = '0;
          gate_d = 1'b0;
        end
        default: begin
          state_d = FAULT;
          freq_d = '0;
          gate_d = 1'b0;
        end
      endcase
    end
  end
  // Registered outputs, tick divider and update strobe
  always_ff @(posedge clk_50) begin
    if (rst) begin
      cnt_q <= '0;
      state_q <= IDLE;
      freq_q <= '0;
      gate_q <= 1'b0;
      amp_q <= '0;
      upd_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
      freq_q <= freq_d;
      gate_q <= gate_d;
      amp_q <= amp_d;
      upd_q <= amp_d != amp_q;
      flt_q <= state_d == FAULT;
    end
  end
  assign freq_out = freq_q;
  assign amp_out = amp_q;
  assign update = upd_q;
  assign gate_en = gate_q;
  assign state_out = state_q;
  assign fault_latched = flt_q;
endmodule

// File: tb/tb_vf_ramp_ctrl.sv
// tb_vf_ramp_ctrl: directed and randomized checks of vf_ramp_ctrl against a cycle-level behavioural model
module tb_vf_ramp_ctrl;
  localparam int DIV = 4;
  localparam int FMIN = 10;
  localparam int FMAX = 600;
  logic clk_50 = 0, rst = 1, start = 0, stop = 0, fault_in = 0, fault_clr = 0;
  logic [9:0] f_target = 0;
  logic [9:0] freq_out;
  logic [11:0] amp_out;
  logic update, gate_en, fault_latched;
  logic [2:0] state_out;
  int errors = 0, checks = 0, upd_seen = 0;
  int m_st = 0, m_f = 0, m_a = 0, m_ph = 0, m_g = 0, m_u = 0;
  int m_t, m_old, m_na;
  bit m_tk;

  vf_ramp_ctrl #(.RAMP_DIV(DIV)) dut (
    .clk_50(clk_50), .rst(rst), .start(start), .stop(stop), .fault_in(fault_in),
    .fault_clr(fault_clr), .f_target(f_target), .freq_out(freq_out), .amp_out(amp_out),
    .update(update), .gate_en(gate_en), .state_out(state_out), .fault_latched(fault_latched)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: modes 0 idle,1 ramping,2 running,3 stopping,4 fault; freq in 0.1 Hz
  always @(posedge clk_50) begin
    if (rst) begin
      m_st = 0; m_f = 0; m_a = 0; m_g = 0; m_u = 0; m_ph = 0;
    end else begin
      m_tk = m_ph == DIV - 1;
      m_ph = (m_ph + 1) % DIV;
      m_t = f_target < FMIN ? FMIN : (f_target > FMAX ? FMAX : int'(f_target));
      m_old = m_f;
      if (fault_in) begin
        m_st = 4; m_f = 0; m_g = 0;
      end else if (m_st == 0) begin
        if (start && !stop && f_target != 0) begin m_st = 1; m_f = FMIN; m_g = 1; end
      end else if (m_st == 1 || m_st == 2) begin
        if (stop || !start) m_st = 3;
        else if (m_st == 2) begin
          if (m_t != m_f) m_st = 1;
        end else begin
          if (m_tk && m_f < m_t) m_f = m_f + 1;
          else if (m_tk && m_f > m_t) m_f = m_f - 1;
          if (m_f == m_t) m_st = 2;
        end
      end else if (m_st == 3) begin
        if (m_f == FMIN) begin m_st = 0; m_f = 0; m_g = 0; end
        else if (m_tk) m_f = m_f - 1;
      end else if (fault_clr) m_st = 0;
      m_na = m_old * 109 / 16;
      if (m_na > 4095) m_na = 4095;
`ifdef VF_BOOST_EN
      if (m_na < 410) m_na = 410;
`endif
      if (!m_g) m_na = 0;
      m_u = m_na != m_a;
      m_a = m_na;
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    @(posedge clk_50);
    forever begin
      @(negedge clk_50);
      chk("freq_out", freq_out, m_f);
      chk("amp_out", amp_out, m_a);
      chk("update", update, m_u);
      chk("gate_en", gate_en, m_g);
      chk("state_out", state_out, m_st);
      chk("fault_latched", fault_latched, m_st == 4);
      if (update) upd_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (state_out != 3'(s) && n < budget) begin @(negedge clk_50); n++; end
    checks++;
    if (state_out != 3'(s)) begin
      errors++;
      $display("FAIL timeout %s: state %0d expected %0d", nm, state_out, s);
    end
  endtask

  task automatic wait_freq(input int f, input int budget, input string nm);
    int n = 0;
    while (freq_out != 10'(f) && n < budget) begin @(negedge clk_50); n++; end
    checks++;
    if (freq_out != 10'(f)) begin
      errors++;
      $display("FAIL timeout %s: freq %0d expected %0d", nm, freq_out, f);
    end
  endtask

  initial begin
    int u0;
    cyc(3);
    rst = 0;
    chk("reset freq", freq_out, 0);
    chk("reset amp", amp_out, 0);
    chk("reset gate", gate_en, 0);
    chk("reset state", state_out, 0);
    start = 1; f_target = 600;
    cyc(1);
    chk("entry state", state_out, 1);
    chk("entry freq", freq_out, 10);
    chk("entry gate", gate_en, 1);
    cyc(1);
    chk("entry amp", amp_out, 68);
    chk("entry update", update, 1);
    wait_state(2, 3000, "ramp up");
    chk("top freq", freq_out, 600);
    cyc(1);
    chk("top amp", amp_out, 4087);
    u0 = upd_seen;
    f_target = 300;
    cyc(1);
    wait_state(2, 2000, "ramp down");
    cyc(1);
    chk("mid freq", freq_out, 300);
    chk("mid amp", amp_out, 2043);
    chk("down updates", upd_seen - u0, 300);
    cyc(5);
    chk("static update", update, 0);
    stop = 1;
    wait_state(0, 2000, "stop");
    chk("stop freq", freq_out, 0);
    chk("stop gate", gate_en, 0);
    chk("stop amp", amp_out, 0);
    stop = 0; start = 0;
    cyc(3);
    start = 1; f_target = 600;
    wait_freq(250, 2000, "fault ramp");
    fault_in = 1;
    cyc(1);
    chk("fault gate", gate_en, 0);
    chk("fault freq", freq_out, 0);
    chk("fault latched", fault_latched, 1);
    start = 0; fault_clr = 1;
    cyc(1);
    fault_clr = 0;
    chk("clr ignored", state_out, 4);
    fault_in = 0;
    cyc(2);
    chk("fault held", state_out, 4);
    fault_clr = 1;
    cyc(1);
    fault_clr = 0;
    chk("fault cleared", state_out, 0);
    chk("cleared latch", fault_latched, 0);
    start = 1; f_target = 900;
    wait_state(2, 3000, "clamp high");
    chk("clamp high freq", freq_out, 600);
    start = 0;
    wait_state(0, 3000, "clamp stop");
    start = 1; f_target = 3;
    cyc(2);
    chk("clamp low state", state_out, 2);
    cyc(20);
    chk("clamp low freq", freq_out, 10);
    start = 0;
    wait_state(0, 100, "low stop");
    start = 1; f_target = 0;
    cyc(10);
    chk("zero target state", state_out, 0);
    chk("zero target gate", gate_en, 0);
`ifdef VF_BOOST_EN
    f_target = 20;
    cyc(2);
    chk("boost ramp amp", amp_out, 410);
    wait_state(2, 200, "boost run");
    cyc(2);
    chk("boost run amp", amp_out, 410);
`endif
    start = 0;
    wait_state(0, 3000, "pre random");
    for (int i = 0; i < 60; i++) begin
      start = $urandom_range(0, 9) < 8;
      stop = $urandom_range(0, 9) == 0;
      fault_in = $urandom_range(0, 19) == 0;
      f_target = $urandom_range(0, 1) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 40));
      rst = $urandom_range(0, 29) == 0;
      cyc(1);
      rst = 0;
      fault_clr = $urandom_range(0, 1);
      cyc(1);
      fault_clr = 0;
      fault_in = fault_in && $urandom_range(0, 1);
      cyc($urandom_range(1, 400));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vf_ramp_ctrl.md
# vf_ramp_ctrl

Volts-per-hertz ramp scheduler for the inverter PWM chain. Takes run/stop/fault commands and a target output frequency, then ramps the commanded frequency at a fixed rate. Derives the matching 12-bit modulation amplitude and gates the dead-time driver stage. Sits between the operator/command interface and the sine reference generator plus PWM/dead-time logic, all clocked from clk_50.

## Interface
Parameters:
- FREQ_W, 10, width of frequency words (unit 0.1 Hz)
- F_MIN, 10, start/stop frequency (1.0 Hz)
- F_MAX, 600, frequency ceiling (60.0 Hz)
- RAMP_DIV, 50000, clk_50 cycles per ramp tick (1 ms)
- VF_GAIN, 109, V/f slope; amplitude = (freq*VF_GAIN)>>4
- BOOST_AMP, 410, low-speed amplitude floor (only with VF_BOOST_EN)

Ports:
- clk_50  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- start  in  1  run request, level, sampled each cycle
- stop  in  1  stop request, level
- fault_in  in  1  external trip (overcurrent/overvoltage), level
- fault_clr  in  1  one-cycle pulse clearing a latched fault
- f_target  in  FREQ_W  requested frequency, 0.1 Hz units
- freq_out  out  FREQ_W  commanded frequency to the sine generator
- amp_out  out  12  commanded reference amplitude, 0..4095
- update  out  1  one-cycle strobe: freq_out/amp_out pair changed
- gate_en  out  1  driver enable, gates driver_1/driver_2
- state_out  out  3  current FSM state encoding
- fault_latched  out  1  high while in FAULT

## Operation
- All outputs are registered. Reset values: freq_out=0, amp_out=0, update=0, gate_en=0, state_out=IDLE, fault_latched=0. The tick divider also clears.
- Effective target: tgt = clamp(f_target, F_MIN, F_MAX).
- Command priority, evaluated every cycle: fault_in > stop > start / target change.
- FSM states: IDLE=0, RAMP=1, RUN=2, STOPPING=3, FAULT=4. Codes 5-7 are illegal and map to FAULT.
- IDLE: gate_en=0, freq_out=0.
  - Transition to RAMP when start=1, stop=0, fault_in=0 and f_target!=0.
  - On entry, freq_out=F_MIN and gate_en=1.
  - With start=1 and f_target=0, stay in IDLE.
- RAMP: on each tick, freq_out moves one LSB toward tgt.
  - When freq_out==tgt, go to RUN (same cycle as the final step).
  - tgt is re-read every tick, so a target change mid-ramp reverses or extends the ramp without leaving RAMP.
- RUN: hold freq_out.
  - If tgt!=freq_out, go to RAMP.
  - If start=0 or stop=1, go to STOPPING.
- STOPPING: on each tick, freq_out decrements by one toward F_MIN.
  - When freq_out==F_MIN, the next cycle enters IDLE with freq_out=0 and gate_en=0.
  - start/target changes are ignored in STOPPING. A restart requires passing through IDLE.
- FAULT: entered from any state on fault_in=1.
  - Same registered cycle: gate_en=0, freq_out=0, amp_out=0, fault_latched=1.
  - Exit to IDLE only on fault_clr=1 with fault_in=0. fault_clr is ignored while fault_in=1.
- Amplitude: amp_out = min(4095, (freq_out*VF_GAIN)>>4).
  - Uses an internal product of FREQ_W+7 bits with saturation.
  - amp_out=0 whenever gate_en=0.
- Tick: a free-running counter 0..RAMP_DIV-1; tick=1 when the count equals RAMP_DIV-1. It is not restarted by state changes.
- freq_out never leaves [0, F_MAX]. It never falls below F_MIN while gate_en=1.

## Timing
- start asserted at cycle N with the other conditions met:
  - state=RAMP, freq_out=F_MIN and gate_en=1 at N+1;
  - amp_out valid and update=1 at N+2.
- amp_out lags freq_out by exactly 1 cycle. update pulses in the cycle amp_out takes the new value, once per freq_out change, and never while values are static.
- Ramp slope is 1 LSB per RAMP_DIV cycles. Default 0.1 Hz/ms, so 1.0→60.0 Hz takes 590 ticks.
- fault_in at cycle N: gate_en=0 at N+1, regardless of state or pending tick.
- stop and fault_in in the same cycle: FAULT wins.
- rst mid-ramp: all outputs are at reset values on the next edge and the FSM is in IDLE.

## Configuration
- VF_BOOST_EN defined:
  - while gate_en=1, amp_out = max(V/f amplitude, BOOST_AMP), compensating stator IR drop at low frequency;
  - update also pulses if the boost floor changes amp_out.
- VF_BOOST_EN undefined: the pure V/f law applies and the BOOST_AMP parameter is unused.

## Test plan
- Reset, then start=1 with f_target=600 and RAMP_DIV=4:
  - freq_out=10 one cycle after start;
  - freq_out steps +1 every 4 cycles and reaches 600 after 590 ticks;
  - state RUN; amp_out=4087.
- In RUN at 600, f_target changes to 300: the ramp goes down to 300, then RUN with amp_out=2043. update fires once per step.
- In RUN, set stop=1: the ramp goes to 10, then IDLE with freq_out=0, gate_en=0 and amp_out=0 one cycle later.
- Mid-ramp at 250, assert fault_in:
  - next cycle gate_en=0, freq_out=0, fault_latched=1;
  - fault_clr while fault_in=1 is ignored;
  - fault_clr after fault_in drops gives IDLE.
- f_target=900 requests clamp to 600, and f_target=3 starts and holds at 10. start with f_target=0 stays in IDLE.
- With VF_BOOST_EN defined, start at f_target=20: amp_out=410 (not 136) throughout the ramp and RUN.
